// File: rtl/muldiv_sequencer.sv
// Issue controller sequencing M-extension ops onto the iterative multiplier and divider.
// Optional MULDIV_DIVREM_FUSE_EN reuses the last division's quotient/remainder pair.

module muldiv_sequencer #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic [2:0]         req_funct3,
  input  logic [WIDTH-1:0]   req_a,
  input  logic [WIDTH-1:0]   req_b,
  input  logic [4:0]         req_rd,
  input  logic               flush,
  output logic               req_ready,
  output logic               stall,
  output logic               resp_valid,
  output logic [WIDTH-1:0]   resp_data,
  output logic [4:0]         resp_rd,
  output logic               mul_start,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  output logic [1:0]         mul_op,
  input  logic [2*WIDTH-1:0] mul_result,
  input  logic               mul_done,
  output logic               div_start,
  output logic [WIDTH-1:0]   div_a,
  output logic [WIDTH-1:0]   div_b,
  output logic [1:0]         div_op,
  input  logic [WIDTH-1:0]   div_quotient,
  input  logic [WIDTH-1:0]   div_remainder,
  input  logic               div_done,
  output logic               timeout_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StMulBusy, StDivBusy, StDone, StDrain} state_e;

  state_e           state_q;
  logic [2:0]       funct3_q;
  logic [WIDTH-1:0] a_q, b_q, result_q;
  logic [4:0]       rd_q;
  logic [CntW-1:0]  cnt_q;
  logic             mul_start_q, div_start_q, timeout_q, timed_out_q;

  logic             accept, overflow, unit_done, cnt_max, fuse_hit;
  logic [WIDTH-1:0] unit_result, fuse_data;

  assign accept    = (state_q == StIdle) & req_valid & ~flush;
  assign overflow  = ~req_funct3[0] & (req_a == MinNeg) & (req_b == '1);
  assign unit_done = funct3_q[2] ? div_done : mul_done;
  assign cnt_max   = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    unit_result = '0;
    if (funct3_q[2]) begin
      unit_result = funct3_q[1] ? div_remainder : div_quotient;
    end else if (funct3_q[1:0] == 2'b00) begin
      unit_result = mul_result[WIDTH-1:0];
    end else begin
      unit_result = mul_result[2*WIDTH-1:WIDTH];
    end
  end

`ifdef MULDIV_DIVREM_FUSE_EN
  logic [WIDTH-1:0] tag_a_q, tag_b_q, tag_quo_q, tag_rem_q;
  logic             tag_signed_q, tag_valid_q;
  logic             div_complete, timeout_hit;

  assign div_complete = (state_q == StDivBusy) & div_done & ~flush;
  assign timeout_hit  = ((state_q == StMulBusy) | (state_q == StDivBusy)) & ~flush &
                        ~unit_done & cnt_max;
  assign fuse_hit     = tag_valid_q & (req_a == tag_a_q) & (req_b == tag_b_q) &
                        (tag_signed_q == ~req_funct3[0]);
  assign fuse_data    = req_funct3[1] ? tag_rem_q : tag_quo_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_a_q      <= '0;
      tag_b_q      <= '0;
      tag_quo_q    <= '0;
      tag_rem_q    <= '0;
      tag_signed_q <= 1'b0;
      tag_valid_q  <= 1'b0;
    end else if (timeout_hit) begin
      tag_valid_q <= 1'b0;
    end else if (div_complete) begin
      tag_a_q      <= a_q;
      tag_b_q      <= b_q;
      tag_quo_q    <= div_quotient;
      tag_rem_q    <= div_remainder;
      tag_signed_q <= ~funct3_q[0];
      tag_valid_q  <= 1'b1;
    end
  end
`else
  assign fuse_hit  = 1'b0;
  assign fuse_data = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      funct3_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rd_q        <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
      mul_start_q <= 1'b0;
      div_start_q <= 1'b0;
      timeout_q   <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            funct3_q <= req_funct3;
            a_q      <= req_a;
            b_q      <= req_b;
            rd_q     <= req_rd;
            cnt_q    <= '0;
            if (!req_funct3[2]) begin
              mul_start_q <= 1'b1;
              state_q     <= StMulBusy;
            end else if (req_b == '0) begin
              result_q <= req_funct3[1] ? req_a : '1;
              state_q  <= StDone;
            end else if (overflow) begin
              result_q <= req_funct3[1] ? '0 : MinNeg;
              state_q  <= StDone;
            end else if (fuse_hit) begin
              result_q <= fuse_data;
              state_q  <= StDone;
            end else begin
              div_start_q <= 1'b1;
              state_q     <= StDivBusy;
            end
          end
        end
        StMulBusy, StDivBusy: begin
          if (flush || unit_done || cnt_max) begin
            mul_start_q <= 1'b0;
            div_start_q <= 1'b0;
            cnt_q       <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
          // A unit finishing on the flush edge has nothing left to drain.
          if (flush) begin
            state_q <= unit_done ? StIdle : StDrain;
          end else if (unit_done) begin
            result_q <= unit_result;
            state_q  <= StDone;
          end else if (cnt_max) begin
            timeout_q   <= 1'b1;
            timed_out_q <= 1'b1;
            result_q    <= '0;
            state_q     <= StDrain;
          end
        end
        StDrain: begin
          if (unit_done || cnt_max) begin
            cnt_q       <= '0;
            timed_out_q <= 1'b0;
            state_q     <= timed_out_q ? StDone : StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready   = (state_q == StIdle);
  assign stall       = (state_q == StMulBusy) | (state_q == StDivBusy) |
                       (state_q == StDrain) | accept;
  assign resp_valid  = (state_q == StDone) & ~flush;
  assign resp_data   = result_q;
  assign resp_rd     = rd_q;
  assign mul_start   = mul_start_q;
  assign mul_a       = a_q;
  assign mul_b       = b_q;
  assign mul_op      = funct3_q[1:0];
  assign div_start   = div_start_q;
  assign div_a       = a_q;
  assign div_b       = b_q;
  assign div_op      = funct3_q[1:0];
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: behavioural mul/div units plus an arithmetic
// reference model of every M-extension result and its response latency.

module tb_muldiv_sequencer;

  localparam logic [31:0] MIN_NEG  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_a = '0, req_b = '0;
  logic [4:0]  req_rd = '0;
  logic        flush = 1'b0;
  logic        req_ready, stall, resp_valid;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        mul_start, div_start, timeout_err;
  logic [31:0] mul_a, mul_b, div_a, div_b;
  logic [1:0]  mul_op, div_op;
  logic [63:0] mul_result = '0;
  logic        mul_done = 1'b0, div_done = 1'b0;
  logic [31:0] div_quotient = '0, div_remainder = '0;

  int n_checks = 0;
  int n_fail   = 0;

  int mul_lat = 1, div_lat = 1;
  bit m_run = 0, d_run = 0;
  int m_cnt = 0, d_cnt = 0;
  logic [31:0] m_a, m_b, d_a, d_b;
  logic [1:0]  m_op, d_op;

  // Bench-side record of the last division completed by the unit.
  bit          tag_v = 0, tag_s = 0;
  logic [31:0] tag_a = '0, tag_b = '0;

  muldiv_sequencer #(.WIDTH(32), .TIMEOUT_CYCLES(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_funct3    (req_funct3),
    .req_a         (req_a),
    .req_b         (req_b),
    .req_rd        (req_rd),
    .flush         (flush),
    .req_ready     (req_ready),
    .stall         (stall),
    .resp_valid    (resp_valid),
    .resp_data     (resp_data),
    .resp_rd       (resp_rd),
    .mul_start     (mul_start),
    .mul_a         (mul_a),
    .mul_b         (mul_b),
    .mul_op        (mul_op),
    .mul_result    (mul_result),
    .mul_done      (mul_done),
    .div_start     (div_start),
    .div_a         (div_a),
    .div_b         (div_b),
    .div_op        (div_op),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder),
    .div_done      (div_done),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] unit_product(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
    logic [63:0] sa, sb, ub;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ub = {32'd0, b};
    if (op == 2'b11) return {32'd0, a} * ub;
    if (op == 2'b10) return sa * ub;
    return sa * sb;
  endfunction

  function automatic logic [31:0] exp_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] r;
    p = '0;
    r = '0;
    case (f3)
      3'd0: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; r = p[31:0]; end
      3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; r = p[63:32]; end
      3'd2: begin p = {{32{a[31]}}, a} * {32'd0, b};       r = p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b};             r = p[63:32]; end
      3'd4: r = (b == 0) ? ALL_ONES : (a == MIN_NEG && b == ALL_ONES) ? MIN_NEG
              : 32'($signed(a) / $signed(b));
      3'd5: r = (b == 0) ? ALL_ONES : a / b;
      3'd6: r = (b == 0) ? a : (a == MIN_NEG && b == ALL_ONES) ? 32'd0
              : 32'($signed(a) % $signed(b));
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Behavioural iterative units: run lat cycles from the first cycle start is seen.
  always @(negedge clk) begin
    mul_done = 1'b0;
    div_done = 1'b0;
    if (!rst) begin
      m_run = 0;
      d_run = 0;
    end else begin
      if (m_run) m_cnt++;
      else if (mul_start) begin
        m_run = 1; m_cnt = 1; m_a = mul_a; m_b = mul_b; m_op = mul_op;
      end
      if (m_run && m_cnt >= mul_lat) begin
        mul_done = 1'b1; mul_result = unit_product(m_op, m_a, m_b); m_run = 0;
      end
      if (d_run) d_cnt++;
      else if (div_start) begin
        d_run = 1; d_cnt = 1; d_a = div_a; d_b = div_b; d_op = div_op;
      end
      if (d_run && d_cnt >= div_lat) begin
        div_done = 1'b1;
        if (d_b == 0) begin
          div_quotient = ALL_ONES; div_remainder = d_a;
        end else if (!d_op[0]) begin
          div_quotient  = 32'($signed(d_a) / $signed(d_b));
          div_remainder = 32'($signed(d_a) % $signed(d_b));
        end else begin
          div_quotient = d_a / d_b; div_remainder = d_a % d_b;
        end
        d_run = 0;
      end
    end
  end

  task automatic drive_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd);
    req_valid = 1'b1; req_funct3 = f3; req_a = a; req_b = b; req_rd = rd;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    tag_v = 0;
    #1;
    check("rst_timeout_err", timeout_err, 1'b0);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_starts", {mul_start, div_start}, 2'b00);
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int lat);
    bit fast, fused, unit_path;
    int got_cyc, mc, dc;
    fast = f3[2] && (b == 0 || (!f3[0] && a == MIN_NEG && b == ALL_ONES));
    fused = 0;
`ifdef MULDIV_DIVREM_FUSE_EN
    fused = f3[2] && !fast && tag_v && a == tag_a && b == tag_b && tag_s == !f3[0];
`endif
    unit_path = !fast && !fused;
    mul_lat = lat;
    div_lat = lat;
    @(negedge clk);
    drive_req(f3, a, b, rd);
    #1;
    check("accept_ready", req_ready, 1'b1);
    check("accept_stall", stall, 1'b1);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_a = $urandom; req_b = $urandom; req_rd = 5'($urandom);
    got_cyc = 0; mc = 0; dc = 0;
    for (int c = 1; c <= lat + 20 && got_cyc == 0; c++) begin
      @(negedge clk);
      #1;
      if (resp_valid) begin
        got_cyc = c;
        check($sformatf("resp_data f3=%0d a=%h b=%h", f3, a, b), resp_data,
              exp_result(f3, a, b));
        check("resp_rd", resp_rd, rd);
        check("resp_stall_low", stall, 1'b0);
      end else begin
        mc += int'(mul_start);
        dc += int'(div_start);
      end
    end
    check("resp_latency", got_cyc, unit_path ? lat + 1 : 1);
    check("mul_start_cycles", mc, !f3[2] ? lat : 0);
    check("div_start_cycles", dc, (f3[2] && unit_path) ? lat : 0);
    @(negedge clk);
    #1;
    check("resp_single_pulse", resp_valid, 1'b0);
    check("ready_after_resp", req_ready, 1'b1);
    if (f3[2] && unit_path) begin
      tag_v = 1; tag_a = a; tag_b = b; tag_s = !f3[0];
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1);
  end

  initial begin
    int rdy_cyc, to_cyc, resp_cyc, dc;
    bit resp_seen;
    logic [2:0]  f3;
    logic [31:0] a, b;
    int sel;

    #1;
    check("reset_req_ready", req_ready, 1'b1);
    check("reset_stall", stall, 1'b0);
    check("reset_resp", {resp_valid, resp_data, resp_rd}, '0);
    check("reset_starts", {mul_start, div_start, timeout_err}, 3'b000);
    check("reset_operands", {mul_a, mul_b, div_a, div_b}, '0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 3);
    run_op(3'd5, 32'd100, 32'd0, 5'd6, 4);
    run_op(3'd7, 32'd100, 32'd0, 5'd7, 4);
    run_op(3'd4, MIN_NEG, ALL_ONES, 5'd8, 4);
    run_op(3'd6, MIN_NEG, ALL_ONES, 5'd8, 4);
    run_op(3'd1, 32'h8000_0001, 32'h7FFF_FFFF, 5'd2, 2);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1);

    // Killed division: start drops on the flush edge, drain waits for the unit.
    div_lat = 8;
    @(negedge clk);
    drive_req(3'd4, 32'd50, 32'd7, 5'd9);
    @(posedge clk);
    #1 req_valid = 1'b0;
    rdy_cyc = 0; resp_seen = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 2) flush = 1'b1;
      if (c == 3) flush = 1'b0;
      #1;
      if (c == 2) check("div_start_before_flush", div_start, 1'b1);
      if (c == 3) check("div_start_after_flush", div_start, 1'b0);
      if (c == 3) check("drain_stall", stall, 1'b1);
      if (resp_valid) resp_seen = 1;
      if (req_ready && rdy_cyc == 0) rdy_cyc = c;
    end
    check("flush_no_resp", resp_seen, 1'b0);
    check("drain_ready_cycle", rdy_cyc, 9);

    // Flush coinciding with done skips the drain.
    mul_lat = 2;
    @(negedge clk);
    drive_req(3'd0, 32'd3, 32'd4, 5'd10);
    @(posedge clk);
    #1 req_valid = 1'b0;
    rdy_cyc = 0; resp_seen = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 2) flush = 1'b1;
      if (c == 3) flush = 1'b0;
      #1;
      if (resp_valid) resp_seen = 1;
      if (req_ready && rdy_cyc == 0) rdy_cyc = c;
    end
    check("flush_done_no_resp", resp_seen, 1'b0);
    check("flush_done_ready_cycle", rdy_cyc, 3);

    // Flush in the response cycle suppresses the pulse.
    @(negedge clk);
    drive_req(3'd5, 32'd9, 32'd0, 5'd11);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    #1 check("flush_in_done_resp", resp_valid, 1'b0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_in_done_ready", req_ready, 1'b1);
    check("flush_in_done_resp2", resp_valid, 1'b0);

    // A request alongside flush in IDLE is not accepted.
    @(negedge clk);
    drive_req(3'd0, 32'd1, 32'd1, 5'd1);
    flush = 1'b1;
    #1 check("idle_flush_stall", stall, 1'b0);
    @(negedge clk);
    req_valid = 1'b0;
    flush = 1'b0;
    #1 check("idle_flush_no_accept", {req_ready, mul_start}, 2'b10);

    run_op(3'd4, 32'd50, 32'd7, 5'd12, 4);
    run_op(3'd6, 32'd50, 32'd7, 5'd13, 4);

    // Divider that never finishes: watchdog, drain window, zero response.
    div_lat = 1_000_000;
    @(negedge clk);
    drive_req(3'd4, 32'd1000, 32'd3, 5'd17);
    @(posedge clk);
    #1 req_valid = 1'b0;
    to_cyc = 0; resp_cyc = 0; dc = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      #1;
      dc += int'(div_start);
      if (timeout_err && to_cyc == 0) to_cyc = c;
      if (resp_valid && resp_cyc == 0) begin
        resp_cyc = c;
        check("timeout_resp_data", resp_data, 32'd0);
        check("timeout_resp_rd", resp_rd, 5'd17);
      end
    end
    tag_v = 0;
    check("timeout_flag_cycle", to_cyc, 65);
    check("timeout_resp_cycle", resp_cyc, 129);
    check("timeout_div_start_cycles", dc, 64);
    check("timeout_sticky", timeout_err, 1'b1);
    do_reset();

    // Reset mid-operation drops start immediately.
    mul_lat = 1_000_000;
    @(negedge clk);
    drive_req(3'd3, 32'd5, 32'd6, 5'd4);
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1 check("mid_op_start_high", mul_start, 1'b1);
    do_reset();

    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 32'd0;
      if (sel == 1) begin a = MIN_NEG; b = ALL_ONES; end
      if (sel >= 2 && sel <= 4 && tag_v) begin a = tag_a; b = tag_b; end
      if (sel == 5) b = 32'($urandom_range(1, 15));
      run_op(f3, a, b, 5'($urandom), $urandom_range(1, 6));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
